// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder family: sequencer states,
// one-hot expansion and the all-inactive line pattern.
package scan_decoder_pkg;

  localparam int MAX_SEL_W = 6;
  localparam int MAX_LINES = 1 << MAX_SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Lines at and above 2^width are forced to zero so callers can truncate freely.
  function automatic logic [MAX_LINES-1:0] onehot(input logic [MAX_SEL_W-1:0] code,
                                                  input int width);
    logic [MAX_LINES-1:0] mask;
    mask = (MAX_LINES'(1) << (1 << width)) - MAX_LINES'(1);
    return (MAX_LINES'(1) << code) & mask;
  endfunction

  function automatic logic [MAX_LINES-1:0] inactive_pattern(input logic active_low);
    return {MAX_LINES{active_low}};
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Bundle of the scan_decoder control/status/line signals. Port f exists only
// when SCAN_DECODER_FUNC_EN is defined.
interface scan_decoder_if #(
  parameter int SEL_W = 2
);

  logic                    en;
  logic [SEL_W-1:0]        sel;
  logic                    scan_start;
  logic                    scan_busy;
  logic                    scan_done;
  logic [SEL_W-1:0]        code;
  logic [(1<<SEL_W)-1:0]   dout;
`ifdef SCAN_DECODER_FUNC_EN
  logic                    f;

  modport master (output en, sel, scan_start,
                  input  scan_busy, scan_done, code, dout, f);
  modport slave  (input  en, sel, scan_start,
                  output scan_busy, scan_done, code, dout, f);
`else
  modport master (output en, sel, scan_start,
                  input  scan_busy, scan_done, code, dout);
  modport slave  (input  en, sel, scan_start,
                  output scan_busy, scan_done, code, dout);
`endif

endinterface

// File: rtl/scan_decoder_core.sv
// Combinational SEL_W-to-2^SEL_W line decoder with enable and selectable
// output polarity; disabled means every line sits at its inactive level.
module decoder_core
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] dout
);

  localparam int LINES = 1 << SEL_W;

  logic [LINES-1:0] hot;

  always_comb begin
    hot = LINES'(onehot(MAX_SEL_W'(sel), SEL_W));
    if (!en) begin
      dout = LINES'(inactive_pattern(ACTIVE_LOW));
    end else if (ACTIVE_LOW) begin
      dout = ~hot;
    end else begin
      dout = hot;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered line decoder with autoscan sequencer (IDLE/SCAN/DONE).
// Optional registered minterm output f is built when SCAN_DECODER_FUNC_EN is defined.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int                     SEL_W        = 2,
  parameter bit                     ACTIVE_LOW   = 1'b1,
  parameter int                     DWELL        = 1,
  parameter logic [(1<<SEL_W)-1:0]  MINTERM_MASK = 'b0110
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_decoder_if.slave bus
);

  localparam int                LINES      = 1 << SEL_W;
  localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0]  LAST_CODE  = SEL_W'(LINES - 1);
  localparam logic [DW_W-1:0]   LAST_DWELL = DW_W'(DWELL - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [SEL_W-1:0] code_q, code_d;
  logic [LINES-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] cur_code;

  decoder_core #(
    .SEL_W      (SEL_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .en   (bus.en),
    .sel  (cur_code),
    .dout (dout_d)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    // DONE still drives the scan counter so the last code gets its final cycle.
    cur_code = (state_q == IDLE) ? bus.sel : cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.en && bus.scan_start) begin
          state_d = SCAN;
          cnt_d   = '0;
          dwell_d = '0;
        end
      end
      SCAN: begin
        if (bus.en) begin
          if (dwell_q == LAST_DWELL) begin
            dwell_d = '0;
            if (cnt_q == LAST_CODE) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    code_d = bus.en ? cur_code : code_q;
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

`ifdef SCAN_DECODER_FUNC_EN
  logic f_q, f_d;

  always_comb begin
    f_d = bus.en && (|(onehot(MAX_SEL_W'(cur_code), SEL_W) & MAX_LINES'(MINTERM_MASK)));
  end

  assign bus.f = f_q;
`else
  // The minterm mask only matters in the function-output build.
  if (MINTERM_MASK == '0) begin : g_mask_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dwell_q <= '0;
      code_q  <= '0;
      dout_q  <= LINES'(inactive_pattern(ACTIVE_LOW));
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCAN_DECODER_FUNC_EN
      f_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      code_q  <= code_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SCAN_DECODER_FUNC_EN
      f_q     <= f_d;
`endif
    end
  end

  assign bus.scan_busy = busy_q;
  assign bus.scan_done = done_q;
  assign bus.code      = code_q;
  assign bus.dout      = dout_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (SEL_W=2, active-low, DWELL=2); adds a
// SEL_W=4 minterm-function instance when SCAN_DECODER_FUNC_EN is defined.
`timescale 1ns/1ps
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  scan_decoder_if #(.SEL_W(2)) bus ();

  scan_decoder #(
    .SEL_W        (2),
    .ACTIVE_LOW   (1'b1),
    .DWELL        (2),
    .MINTERM_MASK (4'b0110)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef SCAN_DECODER_FUNC_EN
  logic rst4_n;
  scan_decoder_if #(.SEL_W(4)) bus4 ();

  scan_decoder #(
    .SEL_W        (4),
    .ACTIVE_LOW   (1'b0),
    .DWELL        (1),
    .MINTERM_MASK (16'h0DD0)
  ) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4)
  );

  typedef struct packed {
    logic [3:0] code;
    logic       f;
  } exp4_t;
  exp4_t sb4_q[$];

  // F = (AB' + A'B)(C + D'), A = code[3]
  function automatic logic fref(input logic [3:0] c);
    return (c[3] ^ c[2]) & (c[1] | ~c[0]);
  endfunction
`endif

  typedef struct packed {
    logic [3:0] dout;
    logic [1:0] code;
    logic       busy;
    logic       done;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic [3:0] run_dout [7] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111};
  logic [1:0] run_code [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

  task automatic check_out(input string tag);
    exp_t x;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard got 0 entries expected 1", tag);
    end
    if (sb_q.size() != 0) begin
      x = sb_q.pop_front();
      checks++;
      assert (bus.dout === x.dout) else begin
        errors++;
        $error("FAIL %s dout got %b expected %b", tag, bus.dout, x.dout);
      end
      checks++;
      assert (bus.code === x.code) else begin
        errors++;
        $error("FAIL %s code got %0d expected %0d", tag, bus.code, x.code);
      end
      checks++;
      assert (bus.scan_busy === x.busy) else begin
        errors++;
        $error("FAIL %s scan_busy got %b expected %b", tag, bus.scan_busy, x.busy);
      end
      checks++;
      assert (bus.scan_done === x.done) else begin
        errors++;
        $error("FAIL %s scan_done got %b expected %b", tag, bus.scan_done, x.done);
      end
    end
  endtask

  // Drive one cycle of stimulus, record what must appear after the edge, then check it.
  task automatic step(input logic r, input logic e, input logic [1:0] s, input logic st,
                      input logic [3:0] ed, input logic [1:0] ec, input logic eb,
                      input logic edn, input string tag);
    @(negedge clk);
    rst_n          = r;
    bus.en         = e;
    bus.sel        = s;
    bus.scan_start = st;
    sb_q.push_back(exp_t'{ed, ec, eb, edn});
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

`ifdef SCAN_DECODER_FUNC_EN
  task automatic step4(input logic r, input logic e, input logic [3:0] s, input logic st,
                       input logic [3:0] ec, input logic ef, input string tag);
    exp4_t x;
    @(negedge clk);
    rst4_n          = r;
    bus4.en         = e;
    bus4.sel        = s;
    bus4.scan_start = st;
    sb4_q.push_back(exp4_t'{ec, ef});
    @(posedge clk);
    #1;
    x = sb4_q.pop_front();
    checks++;
    assert (bus4.f === x.f) else begin
      errors++;
      $error("FAIL %s f got %b expected %b", tag, bus4.f, x.f);
    end
    checks++;
    assert (bus4.code === x.code) else begin
      errors++;
      $error("FAIL %s code got %0d expected %0d", tag, bus4.code, x.code);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.sel        = 2'd0;
    bus.scan_start = 1'b0;
`ifdef SCAN_DECODER_FUNC_EN
    rst4_n          = 1'b0;
    bus4.en         = 1'b0;
    bus4.sel        = 4'd0;
    bus4.scan_start = 1'b0;
`endif

    // reset state, then basic decode and enable behaviour
    step(1'b0, 1'b1, 2'd2, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b1, 2'd2, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, "reset_hold");
    step(1'b1, 1'b1, 2'd2, 1'b0, 4'b1011, 2'd2, 1'b0, 1'b0, "idle_sel2");
    step(1'b1, 1'b0, 2'd1, 1'b0, 4'b1111, 2'd2, 1'b0, 1'b0, "en_off");
    step(1'b1, 1'b0, 2'd3, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0, "start_while_disabled");
    step(1'b1, 1'b1, 2'd0, 1'b0, 4'b1110, 2'd0, 1'b0, 1'b0, "en_on_sel0");
    step(1'b1, 1'b1, 2'd3, 1'b0, 4'b0111, 2'd3, 1'b0, 1'b0, "idle_sel3");

    // full scan, with a stray start pulse that must be ignored
    step(1'b1, 1'b1, 2'd3, 1'b1, 4'b0111, 2'd3, 1'b1, 1'b0, "scan1_start");
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b1, 2'd3, (i == 3), run_dout[i], run_code[i], 1'b1, 1'b0, "scan1_run");
    step(1'b1, 1'b1, 2'd3, 1'b0, 4'b0111, 2'd3, 1'b0, 1'b1, "scan1_done");
    step(1'b1, 1'b1, 2'd3, 1'b0, 4'b0111, 2'd3, 1'b0, 1'b0, "scan1_done_clear");
    step(1'b1, 1'b1, 2'd1, 1'b0, 4'b1101, 2'd1, 1'b0, 1'b0, "idle_after_scan");

    // scan paused for three cycles while code 1 is showing
    step(1'b1, 1'b1, 2'd3, 1'b1, 4'b0111, 2'd3, 1'b1, 1'b0, "scan2_start");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 2'd3, 1'b0, run_dout[i], run_code[i], 1'b1, 1'b0, "scan2_pre");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 2'd3, 1'b0, 4'b1111, 2'd1, 1'b1, 1'b0, "scan2_pause");
    for (int i = 3; i < 7; i++)
      step(1'b1, 1'b1, 2'd3, 1'b0, run_dout[i], run_code[i], 1'b1, 1'b0, "scan2_resume");
    step(1'b1, 1'b1, 2'd3, 1'b0, 4'b0111, 2'd3, 1'b0, 1'b1, "scan2_done");
    step(1'b1, 1'b1, 2'd3, 1'b0, 4'b0111, 2'd3, 1'b0, 1'b0, "scan2_done_clear");

    // reset while code 2 is showing aborts without a done pulse
    step(1'b1, 1'b1, 2'd0, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0, "scan3_start");
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 2'd0, 1'b0, run_dout[i], run_code[i], 1'b1, 1'b0, "scan3_run");
    step(1'b0, 1'b1, 2'd0, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0, "scan3_reset");
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 2'd0, 1'b0, 4'b1110, 2'd0, 1'b0, 1'b0, "after_abort");

`ifdef SCAN_DECODER_FUNC_EN
    step4(1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, "f_reset");
    step4(1'b1, 1'b1, 4'd6, 1'b0, 4'd6, 1'b1, "f_sel0110");
    step4(1'b1, 1'b1, 4'd5, 1'b0, 4'd5, 1'b0, "f_sel0101");
    step4(1'b1, 1'b0, 4'd6, 1'b0, 4'd5, 1'b0, "f_en_off");
    step4(1'b1, 1'b1, 4'd6, 1'b1, 4'd6, 1'b1, "f_scan_start");
    for (int i = 0; i < 16; i++)
      step4(1'b1, 1'b1, 4'd6, 1'b0, 4'(i), fref(4'(i)), "f_scan");
    step4(1'b1, 1'b1, 4'd6, 1'b0, 4'd15, 1'b0, "f_done_cycle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
